// File: rtl/chip8_keypad_scanner.sv
// CHIP-8 4x4 hex keypad scanner: row scan, debounced key state,
// and a single-entry key-press event for the CPU wait-for-key path.
module chip8_keypad_scanner #(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [3:0]  row_n,
   input  logic [3:0]  col_n,
   output logic [15:0] keys,
   output logic        key_valid,
   output logic [3:0]  key_code,
   input  logic        key_ack
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int SW = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] STB_MAX  = SW'(DEBOUNCE);

   typedef enum logic {IDLE, PENDING} ev_state_t;

   logic [3:0]    col_s1, col_s2;
   logic [CW-1:0] cnt;
   logic [1:0]    row_idx;
   logic [15:0]   snap, prev;
   logic          snap_done, seen;
   logic [SW-1:0] stable, stable_d;
   logic [15:0]   snap_keys, new_press;
   logic          upd, hit;
   ev_state_t     state, state_d;
   logic [3:0]    code_d, low_key;

   // matrix bit r*4+c -> CHIP-8 key number
   function automatic logic [15:0] to_keys(input logic [15:0] m);
      logic [15:0] k;
      k = '0;
      k[1]  = m[0];  k[2]  = m[1];  k[3]  = m[2];  k[12] = m[3];
      k[4]  = m[4];  k[5]  = m[5];  k[6]  = m[6];  k[13] = m[7];
      k[7]  = m[8];  k[8]  = m[9];  k[9]  = m[10]; k[14] = m[11];
      k[10] = m[12]; k[0]  = m[13]; k[11] = m[14]; k[15] = m[15];
      return k;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_s1 <= '0;
         col_s2 <= '0;
      end else begin
         col_s1 <= ~col_n;
         col_s2 <= col_s1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         row_idx   <= '0;
         row_n     <= 4'b1110;
         snap      <= '0;
         snap_done <= 1'b0;
      end else if (cnt == CNT_LAST) begin
         cnt                     <= '0;
         row_idx                 <= row_idx + 2'd1;
         row_n                   <= {row_n[2:0], row_n[3]};
         snap[{row_idx, 2'b00} +: 4] <= col_s2;
         snap_done               <= (row_idx == 2'd3);
      end else begin
         cnt       <= cnt + CW'(1);
         snap_done <= 1'b0;
      end
   end

   always_comb begin
      stable_d = stable;
      if (snap_done) begin
         if (seen && snap == prev)
            stable_d = (stable == STB_MAX) ? stable : stable + SW'(1);
         else
            stable_d = SW'(1);
      end
   end

   assign upd       = snap_done && (stable_d == STB_MAX);
   assign snap_keys = to_keys(snap);
   assign new_press = snap_keys & ~keys;
   assign hit       = upd && (new_press != 16'h0000);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev   <= '0;
         seen   <= 1'b0;
         stable <= '0;
         keys   <= '0;
      end else begin
         if (snap_done) begin
            prev   <= snap;
            seen   <= 1'b1;
            stable <= stable_d;
         end
         if (upd)
            keys <= snap_keys;
      end
   end

   always_comb begin
      low_key = 4'h0;
      for (int i = 15; i >= 0; i--)
         if (new_press[i])
            low_key = 4'(i);
   end

   // a fresh press on the ack cycle replaces the consumed event
   always_comb begin
      state_d = state;
      code_d  = key_code;
      unique case (state)
         IDLE: begin
            if (hit) begin
               state_d = PENDING;
               code_d  = low_key;
            end
         end
         PENDING: begin
            if (hit && key_ack)
               code_d = low_key;
            else if (key_ack)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         key_code <= 4'h0;
      end else begin
         state    <= state_d;
         key_code <= code_d;
      end
   end

   assign key_valid = (state == PENDING);

endmodule

// File: tb/tb_chip8_keypad_scanner.sv
// Scoreboard bench for chip8_keypad_scanner (SCAN_DIV=4, DEBOUNCE=2)
// with a zero-delay row/column short keypad model.
module tb_chip8_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [15:0] keys;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_ack = 1'b0;
   logic [15:0] press = 16'h0000;

   chip8_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row_n     (row_n),
      .col_n     (col_n),
      .keys      (keys),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_ack   (key_ack)
   );

   always #5 clk = ~clk;

   // press bit r*4+c shorts row r to column c
   always_comb begin
      col_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (press[r*4+c] && !row_n[r])
               col_n[c] = 1'b0;
   end

   typedef struct packed {
      logic [15:0] k;
      logic        v;
      logic [3:0]  c;
   } obs_t;

   obs_t exp_q[$];
   obs_t last, cur, want;
   int   total = 0;
   int   bad = 0;
   bit   mon_on = 1'b0;

   function automatic obs_t mk(input logic [15:0] k, input logic v,
                               input logic [3:0] c);
      obs_t o;
      o.k = k;
      o.v = v;
      o.c = v ? c : 4'h0;
      return o;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (mon_on) begin
            cur = mk(keys, key_valid, key_code);
            if (cur !== last) begin
               last = cur;
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_change: got keys=%h valid=%b code=%h, expected no change",
                           cur.k, cur.v, cur.c);
               end else begin
                  want = exp_q.pop_front();
                  if (cur !== want) begin
                     bad++;
                     $display("FAIL event: got keys=%h valid=%b code=%h, expected keys=%h valid=%b code=%h",
                              cur.k, cur.v, cur.c, want.k, want.v, want.c);
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL %s: got %0d pending events expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_scan_start();
      logic [3:0] pr;
      int n = 0;
      pr = row_n;
      @(negedge clk);
      while (!(row_n == 4'b1110 && pr == 4'b0111) && n < 100) begin
         pr = row_n;
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("scan_start_timeout", 32'(row_n), 32'hE);
   endtask

   task automatic wait_row(input logic [3:0] r);
      int n = 0;
      while (row_n !== r && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("row_timeout", 32'(row_n), 32'(r));
   endtask

   task automatic measure(output int n);
      n = 0;
      while (!key_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic ack_pulse();
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
   endtask

   initial begin
      int n;
      logic [3:0] er;

      // 1: reset and scan
      repeat (3) @(negedge clk);
      chk("rst_row_n", 32'(row_n), 32'hE);
      chk("rst_keys", 32'(keys), 32'h0);
      chk("rst_valid", 32'(key_valid), 32'h0);
      chk("rst_code", 32'(key_code), 32'h0);
      last   = mk(16'h0000, 1'b0, 4'h0);
      mon_on = 1'b1;
      rst_n  = 1'b1;
      for (int j = 0; j < 32; j++) begin
         if (j > 0) @(negedge clk);
         er = ~(4'b0001 << ((j / 4) % 4));
         chk("row_seq", 32'(row_n), 32'(er));
      end

      // 2: single press, ack, release
      wait_scan_start();
      exp_q.push_back(mk(16'h0020, 1'b1, 4'h5));
      press[5] = 1'b1;
      measure(n);
      chk("press_latency", 32'(n), 32'd33);
      drain("press5");
      exp_q.push_back(mk(16'h0020, 1'b0, 4'h0));
      ack_pulse();
      chk("ack_clear", 32'(key_valid), 32'h0);
      chk("ack_keys", 32'(keys), 32'h0020);
      exp_q.push_back(mk(16'h0000, 1'b0, 4'h0));
      press[5] = 1'b0;
      drain("release5");
      repeat (40) @(negedge clk);

      // 3: bounce on key A
      for (int i = 0; i < 10; i++) begin
         wait_scan_start();
         press[12] = (i % 2 == 0);
      end
      wait_scan_start();
      press[12] = 1'b0;
      repeat (48) @(negedge clk);
      chk("bounce_keys", 32'(keys), 32'h0);
      chk("bounce_valid", 32'(key_valid), 32'h0);

      // 4: simultaneous 1 and F
      exp_q.push_back(mk(16'h8002, 1'b1, 4'h1));
      press[0]  = 1'b1;
      press[15] = 1'b1;
      drain("press1f");
      exp_q.push_back(mk(16'h8002, 1'b0, 4'h0));
      ack_pulse();
      repeat (48) @(negedge clk);
      chk("no_second_event", 32'(key_valid), 32'h0);
      drain("ack1f");
      exp_q.push_back(mk(16'h0000, 1'b0, 4'h0));
      press[0]  = 1'b0;
      press[15] = 1'b0;
      drain("release1f");
      repeat (40) @(negedge clk);

      // 5: events while pending
      exp_q.push_back(mk(16'h0020, 1'b1, 4'h5));
      press[5] = 1'b1;
      drain("pend5");
      exp_q.push_back(mk(16'h0220, 1'b1, 4'h5));
      press[10] = 1'b1;
      drain("press9");
      repeat (40) @(negedge clk);
      wait_scan_start();
      exp_q.push_back(mk(16'h0228, 1'b1, 4'h3));
      press[2] = 1'b1;
      repeat (32) @(negedge clk);
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
      chk("ack_upd_valid", 32'(key_valid), 32'h1);
      chk("ack_upd_code", 32'(key_code), 32'h3);
      drain("press3_ack");
      exp_q.push_back(mk(16'h0228, 1'b0, 4'h0));
      ack_pulse();
      drain("ack3");
      exp_q.push_back(mk(16'h0020, 1'b0, 4'h0));
      press[10] = 1'b0;
      press[2]  = 1'b0;
      drain("release93");

      // 6: reset mid-scan
      wait_row(4'b1011);
      exp_q.push_back(mk(16'h0000, 1'b0, 4'h0));
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_keys", 32'(keys), 32'h0);
      chk("midrst_valid", 32'(key_valid), 32'h0);
      chk("midrst_row_n", 32'(row_n), 32'hE);
      repeat (2) @(negedge clk);
      exp_q.push_back(mk(16'h0020, 1'b1, 4'h5));
      #2 rst_n = 1'b1;
      measure(n);
      chk("rst_press_latency", 32'(n), 32'd33);
      drain("fresh5");
      exp_q.push_back(mk(16'h0020, 1'b0, 4'h0));
      ack_pulse();
      drain("final_ack");
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/chip8_keypad_scanner.md
# chip8_keypad_scanner

Scans the 4x4 CHIP-8 hex keypad and delivers debounced key state plus a single-entry key-press event to the CPU. It is the input side of the CPU's I/O: the CPU drives its 8-bit output, and this block feeds it. `keys` serves the Ex9E/ExA1 instructions. `key_valid`/`key_code`/`key_ack` serve Fx0A (wait for key).

## Interface

Parameters:
- `SCAN_DIV`, default 1000: clock cycles per row period. Must be ≥ 4.
- `DEBOUNCE`, default 4: number of consecutive identical full-matrix snapshots required before `keys` updates. Must be ≥ 1.

Ports:
- `clk`, input, 1: single clock. Everything is rising-edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `row_n`, output, 4: row drive, active-low. Exactly one bit is low at any time.
- `col_n`, input, 4: column sense, active-low. Pulled up externally. Asynchronous to `clk`.
- `keys`, output, 16: debounced state. Bit k = 1 means CHIP-8 key k is pressed.
- `key_valid`, output, 1: a key-press event is pending.
- `key_code`, output, 4: the pending key. Valid while `key_valid` is 1.
- `key_ack`, input, 1: CPU consumes the pending event.

## Operation

- **Key map** (row r, column c maps to key):
  - row 0: 1, 2, 3, C
  - row 1: 4, 5, 6, D
  - row 2: 7, 8, 9, E
  - row 3: A, 0, B, F
- **Synchronizer:** `col_n` passes through a 2-flop synchronizer before any use.
- **Scan:**
  - A row counter, width $clog2(SCAN_DIV), counts 0..SCAN_DIV-1.
  - A row index cycles 0→1→2→3→0. `row_n` = ~(1 << row index).
  - On count SCAN_DIV-1, the synchronized `~col_n` is written into the 4 snapshot bits for the current row. The row index advances on the next edge.
- **Snapshot:** a snapshot is complete on the row-3 sample. In the following cycle it is compared with the previous complete snapshot.
  - Equal: the stable counter increments, saturating at DEBOUNCE.
  - Different: the stable counter is set to 1.
  - After reset, the first snapshot counts as different.
- **Debounce:** when the stable counter reaches DEBOUNCE, `keys` takes the snapshot, in the same cycle as the compare. `keys` is rewritten on every later equal snapshot, which leaves it unchanged.
- **Event FSM:**
  - IDLE → PENDING when a `keys` update has new presses, i.e. (new & ~old) ≠ 0. `key_code` = lowest-numbered newly pressed key; `key_valid` = 1.
  - Other new presses in the same update are dropped.
  - PENDING → IDLE on `key_ack`. `key_valid` is 0 from the next cycle.
  - New presses while PENDING are dropped. `key_code` holds.
  - `key_ack` and a new-press update in the same cycle: stay PENDING with the new `key_code` (the new event wins).
  - `key_ack` in IDLE is ignored.
  - Releases never generate events.
- **Reset:** asynchronous assertion, including mid-scan, immediately applies all reset values. The scan restarts at row 0, count 0. Synchronizer, snapshot, previous snapshot and stable counter are all cleared.

## Timing

- Reset values:
  - `row_n` = 4'b1110
  - `keys` = 16'h0000
  - `key_valid` = 0
  - `key_code` = 4'h0
- Each row is driven for exactly SCAN_DIV cycles; a full scan takes 4·SCAN_DIV cycles.
- Column sampling happens SCAN_DIV-1 cycles after the row drive starts, which gives ≥ 2 cycles of synchronizer settle.
- Press latency: from a press that is stable before a scan starts, `keys`/`key_valid` rise DEBOUNCE full scans later, plus 1 cycle for the compare.
- `key_valid` rises in the same cycle as the `keys` bit that caused it.
- `key_valid` falls 1 cycle after a sampled `key_ack`.
- Outputs are registered, with no combinational paths from inputs to outputs.

## Test plan

Test configuration: SCAN_DIV=4, DEBOUNCE=2, bench keypad model shorts row to column with zero delay.

1. **Reset and scan.** Hold `rst_n` low → `row_n`=1110, `keys`=0000, `key_valid`=0, `key_code`=0. Release → `row_n` sequence 1110, 1101, 1011, 0111, repeating, 4 cycles each.
2. **Single press and ack.** Hold key 5 (row 1, col 1) → after 2 scans + 1 cycle: `keys`=16'h0020, `key_valid`=1, `key_code`=5. Pulse `key_ack` for 1 cycle → `key_valid`=0 next cycle, `keys` stays 0020. Release → `keys`=0000 after 2 scans, no event.
3. **Bounce.** Toggle key A on every alternate scan for 10 scans → `keys` stays 0000, `key_valid` stays 0.
4. **Simultaneous presses.** Press keys 1 and F together → `keys`=16'h8002, `key_code`=1. Ack → no second event for F.
5. **Event while pending.** Key 5 pending, no ack, then press key 9 → `keys`=16'h0220, `key_code` stays 5. Then press 3 while asserting `key_ack` on the update cycle → `key_valid` stays 1, `key_code`=3.
6. **Reset mid-scan.** Key 5 latched; pull `rst_n` low while row 2 is driven → same cycle: `keys`=0, `key_valid`=0, `row_n`=1110. Release with key 5 still held → a fresh event appears after 2 scans.
